l2_lru_port_scheduler: RTL and testbench

// Shares the single read/update pipeline of the L2 LRU block between the fill

---
 rtl/l2_lru_port_scheduler.sv | 115 +++++++++++
 tb/tb_l2_lru_port_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_lru_port_scheduler.sv
// Arbitrates the L2 LRU read port between the fill and access paths, and sequences
// the one-cycle follow-ups (victim way return, MRU update on hit).
module l2_lru_port_scheduler #(
  parameter int NUM_SETS        = 256,
  parameter int NUM_WAYS        = 8,
  parameter int MAX_FILL_STREAK = 4,
  parameter int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int STREAK_WIDTH    = $clog2(MAX_FILL_STREAK + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_req_valid,
  input  logic [SET_INDEX_WIDTH-1:0] fill_req_set,
  output logic                       fill_req_ready,
  output logic                       fill_way_valid,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  input  logic                       access_req_valid,
  input  logic [SET_INDEX_WIDTH-1:0] access_req_set,
  output logic                       access_req_ready,
  input  logic                       access_hit_valid,
  input  logic [WAY_INDEX_WIDTH-1:0] access_hit_way,
  output logic                       lru_fill_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
  input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,
  output logic                       lru_access_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
  output logic                       lru_access_update_en,
  output logic [WAY_INDEX_WIDTH-1:0] lru_access_update_way,
  output logic                       protocol_error,
  output logic [STREAK_WIDTH-1:0]    starve_count
);

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_FILL,
    GRANT_ACCESS
  } grant_state_e;

  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_FILL_STREAK);

  grant_state_e                state_q, state_d;
  logic [STREAK_WIDTH-1:0]     streak_q, streak_d;
  logic                        perr_q;
  logic                        fill_grant, access_grant;
  logic                        hit_illegal;

  // Grants are gated by reset so every output reads 0 while reset is held.
  // NOTE: every signal assigned in always_comb gets a default first; a missing
  // branch would otherwise infer a latch.
  always_comb begin
    fill_grant   = 1'b0;
    access_grant = 1'b0;
    if (!reset) begin
      if (fill_req_valid && !(access_req_valid && streak_q == STREAK_MAX)) begin
        fill_grant = 1'b1;
      end else if (access_req_valid) begin
        access_grant = 1'b1;
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!access_req_valid || access_grant) begin
      streak_d = '0;
    end else if (fill_grant && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State register: remembers which grant was issued last cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= GRANT_IDLE;
      streak_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (hit_illegal) begin
        perr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = GRANT_IDLE;
    if (fill_grant) begin
      state_d = GRANT_FILL;
    end else if (access_grant) begin
      state_d = GRANT_ACCESS;
    end
  end

  // A hit report is only meaningful in the cycle after an access grant.
  always_comb begin
    fill_req_ready        = fill_grant;
    access_req_ready      = access_grant;
    lru_fill_en           = fill_grant;
    lru_fill_set          = fill_grant ? fill_req_set : '0;
    lru_access_en         = access_grant;
    lru_access_set        = access_grant ? access_req_set : '0;
    fill_way_valid        = (state_q == GRANT_FILL);
    fill_way              = (state_q == GRANT_FILL) ? lru_fill_way : '0;
    lru_access_update_en  = (state_q == GRANT_ACCESS) && access_hit_valid;
    lru_access_update_way = lru_access_update_en ? access_hit_way : '0;
    hit_illegal           = access_hit_valid && (state_q != GRANT_ACCESS) && !reset;
    protocol_error        = perr_q;
    starve_count          = streak_q;
  end

endmodule

// File: tb/tb_l2_lru_port_scheduler.sv
// Self-checking bench for l2_lru_port_scheduler: directed vector table, hand-written
// streak and reset sequences, then randomized traffic against a reference model.
module tb_l2_lru_port_scheduler;
  localparam int MAX = 4;
  localparam int SIW = 8;
  localparam int WIW = 3;
  localparam int SCW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           fill_req_valid, access_req_valid, access_hit_valid;
  logic [SIW-1:0] fill_req_set, access_req_set;
  logic [WIW-1:0] access_hit_way, lru_fill_way;
  logic           fill_req_ready, fill_way_valid, access_req_ready;
  logic [WIW-1:0] fill_way, lru_access_update_way;
  logic           lru_fill_en, lru_access_en, lru_access_update_en, protocol_error;
  logic [SIW-1:0] lru_fill_set, lru_access_set;
  logic [SCW-1:0] starve_count;

  l2_lru_port_scheduler #(
    .NUM_SETS(256), .NUM_WAYS(8), .MAX_FILL_STREAK(MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_req_valid(fill_req_valid), .fill_req_set(fill_req_set),
    .fill_req_ready(fill_req_ready), .fill_way_valid(fill_way_valid), .fill_way(fill_way),
    .access_req_valid(access_req_valid), .access_req_set(access_req_set),
    .access_req_ready(access_req_ready),
    .access_hit_valid(access_hit_valid), .access_hit_way(access_hit_way),
    .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
    .lru_access_en(lru_access_en), .lru_access_set(lru_access_set),
    .lru_access_update_en(lru_access_update_en), .lru_access_update_way(lru_access_update_way),
    .protocol_error(protocol_error), .starve_count(starve_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what was granted last cycle, how many fills in a row have
  // overtaken a waiting access, and whether an illegal hit was ever seen.
  int m_streak;
  bit m_last_fill, m_last_acc, m_perr;

  typedef struct {
    bit fv; int fset; bit av; int aset; bit hv; int hway; int lfw;
    bit e_fr; bit e_ar; bit e_fwv; int e_fw; bit e_ue; int e_uw; bit e_perr; int e_sc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_streak = 0; m_last_fill = 0; m_last_acc = 0; m_perr = 0;
  endfunction

  function automatic bit model_fill_ok();
    return !reset && fill_req_valid && !(access_req_valid && m_streak == MAX);
  endfunction

  function automatic bit model_acc_ok();
    return !reset && access_req_valid && !model_fill_ok();
  endfunction

  // Advance the model across the rising edge using the inputs held at that edge.
  task automatic step();
    bit fok, aok;
    @(posedge clk);
    fok = model_fill_ok();
    aok = model_acc_ok();
    if (reset) begin
      model_reset();
    end else begin
      if (access_hit_valid && !m_last_acc) m_perr = 1;
      if (!access_req_valid || aok) m_streak = 0;
      else if (fok && m_streak < MAX) m_streak++;
      m_last_fill = fok;
      m_last_acc  = aok;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit fv, input int fset, input bit av, input int aset,
                       input bit hv, input int hway, input int lfw);
    fill_req_valid   = fv;  fill_req_set   = SIW'(fset);
    access_req_valid = av;  access_req_set = SIW'(aset);
    access_hit_valid = hv;  access_hit_way = WIW'(hway);
    lru_fill_way     = WIW'(lfw);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit fok, aok, ue;
    fok = model_fill_ok();
    aok = model_acc_ok();
    ue  = !reset && m_last_acc && access_hit_valid;
    check({tag, ".fill_ready"}, 32'(fill_req_ready), 32'(fok));
    check({tag, ".access_ready"}, 32'(access_req_ready), 32'(aok));
    check({tag, ".lru_fill_en"}, 32'(lru_fill_en), 32'(fok));
    check({tag, ".lru_access_en"}, 32'(lru_access_en), 32'(aok));
    if (fok) check({tag, ".lru_fill_set"}, 32'(lru_fill_set), 32'(fill_req_set));
    if (aok) check({tag, ".lru_access_set"}, 32'(lru_access_set), 32'(access_req_set));
    check({tag, ".fill_way_valid"}, 32'(fill_way_valid), 32'(m_last_fill && !reset));
    if (m_last_fill && !reset) check({tag, ".fill_way"}, 32'(fill_way), 32'(lru_fill_way));
    check({tag, ".update_en"}, 32'(lru_access_update_en), 32'(ue));
    if (ue) check({tag, ".update_way"}, 32'(lru_access_update_way), 32'(access_hit_way));
    check({tag, ".protocol_error"}, 32'(protocol_error), 32'(m_perr));
    check({tag, ".starve_count"}, 32'(starve_count), 32'(m_streak));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vec_t tbl[13];
    tbl[0]  = '{1, 5, 0, 0, 0, 0, 6,  1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 9, 0, 0, 6,  0, 1, 1, 6, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 1, 3, 0, 0};
    tbl[3]  = '{0, 0, 1, 9, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 7, 1, 2, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 2, 0, 0, 5,  0, 1, 1, 5, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 1, 7, 0,  1, 0, 0, 0, 1, 7, 0, 0};
    tbl[8]  = '{0, 0, 1, 4, 0, 0, 3,  0, 1, 1, 3, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 2, 0,  0, 0, 0, 0, 1, 2, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0};

    reset = 1'b1;
    drive(1, 3, 1, 4, 1, 1, 2);
    @(negedge clk);
    check("in_reset.fill_ready", 32'(fill_req_ready), 0);
    check("in_reset.access_ready", 32'(access_req_ready), 0);
    check("in_reset.lru_fill_en", 32'(lru_fill_en), 0);
    check("in_reset.update_en", 32'(lru_access_update_en), 0);
    do_reset();
    check("reset.fill_way_valid", 32'(fill_way_valid), 0);
    check("reset.protocol_error", 32'(protocol_error), 0);
    check("reset.starve_count", 32'(starve_count), 0);

    // Directed vector table, one row per cycle.
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].fv, tbl[i].fset, tbl[i].av, tbl[i].aset, tbl[i].hv, tbl[i].hway, tbl[i].lfw);
      check({t, ".fill_ready"}, 32'(fill_req_ready), 32'(tbl[i].e_fr));
      check({t, ".access_ready"}, 32'(access_req_ready), 32'(tbl[i].e_ar));
      check({t, ".lru_fill_en"}, 32'(lru_fill_en), 32'(tbl[i].e_fr));
      check({t, ".lru_access_en"}, 32'(lru_access_en), 32'(tbl[i].e_ar));
      if (tbl[i].e_fr) check({t, ".lru_fill_set"}, 32'(lru_fill_set), 32'(tbl[i].fset));
      if (tbl[i].e_ar) check({t, ".lru_access_set"}, 32'(lru_access_set), 32'(tbl[i].aset));
      check({t, ".fill_way_valid"}, 32'(fill_way_valid), 32'(tbl[i].e_fwv));
      if (tbl[i].e_fwv) check({t, ".fill_way"}, 32'(fill_way), 32'(tbl[i].e_fw));
      check({t, ".update_en"}, 32'(lru_access_update_en), 32'(tbl[i].e_ue));
      if (tbl[i].e_ue) check({t, ".update_way"}, 32'(lru_access_update_way), 32'(tbl[i].e_uw));
      check({t, ".protocol_error"}, 32'(protocol_error), 32'(tbl[i].e_perr));
      check({t, ".starve_count"}, 32'(starve_count), 32'(tbl[i].e_sc));
      step();
    end

    // Both requesters held high: four fills, one access, repeating.
    do_reset();
    check("perr_cleared_by_reset", 32'(protocol_error), 0);
    for (int i = 0; i < 15; i++) begin
      drive(1, i, 1, 100, 0, 0, i % 8);
      check($sformatf("streak%0d.fill_ready", i), 32'(fill_req_ready), 32'((i % 5) != 4));
      check($sformatf("streak%0d.access_ready", i), 32'(access_req_ready), 32'((i % 5) == 4));
      check($sformatf("streak%0d.starve_count", i), 32'(starve_count), 32'(i % 5));
      if (i > 0)
        check($sformatf("streak%0d.fill_way_valid", i), 32'(fill_way_valid), 32'(((i - 1) % 5) != 4));
      step();
    end

    // Reset asserted in the cycle after a fill grant, mid-streak.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 20, 1, 21, 0, 0, 4);
      step();
    end
    check("midop.starve_before", 32'(starve_count), 3);
    check("midop.fwv_before", 32'(fill_way_valid), 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("midop.fwv_in_reset", 32'(fill_way_valid), 0);
    check("midop.starve_in_reset", 32'(starve_count), 0);
    check("midop.fill_ready_in_reset", 32'(fill_req_ready), 0);
    check("midop.access_ready_in_reset", 32'(access_req_ready), 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4);
    check("midop.fwv_after", 32'(fill_way_valid), 0);
    check("midop.update_after", 32'(lru_access_update_en), 0);
    check("midop.starve_after", 32'(starve_count), 0);
    step();

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 255),
            $urandom_range(0, 2) != 0, $urandom_range(0, 255),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 7));
      if (m_last_acc && $urandom_range(0, 1) == 1) begin
        access_hit_valid = 1'b1;
        #1;
      end
      check_model($sformatf("rand%0d", i));
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
